// File: rtl/rib_arbiter.sv
// rib_arbiter: registered round-robin arbiter for the four rib bus masters.
// It has a tenure limit for unlocked masters when others are waiting, a
// per-master lock that holds the grant, and a one-cycle switch pulse that
// marks the first cycle of every new grant.
module rib_arbiter #(
   parameter int NUM_M    = 4,
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = $clog2(MAX_HOLD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_M-1:0] req_i,
   input  logic [NUM_M-1:0] lock_i,
   output logic [NUM_M-1:0] grant_o,
   output logic [1:0]       grant_id_o,
   output logic             grant_vld_o,
   output logic [NUM_M-1:0] hold_o,
   output logic             switch_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         last_q, last_d;
   logic [1:0]         grant_id_d;
   logic               grant_vld_d;
   logic [NUM_M-1:0]   grant_d;
   logic               switch_d;
   logic [NUM_M-1:0]   cand;
   logic               others;
   logic [1:0]         pick;

   // Round-robin search: first set bit of mask starting after ptr, wrapping
   // around so that ptr itself is examined last.
   function automatic logic [1:0] rr_pick(input logic [NUM_M-1:0] mask,
                                          input logic [1:0]       ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      // Scan from the farthest offset down so the nearest requester wins.
      for (int k = NUM_M; k >= 1; k--) begin
         idx = ptr + 2'(k);
         if (mask[idx]) rr_pick = idx;
      end
   endfunction

   // Candidates exclude the current owner; in IDLE grant_o is zero so every
   // requester is a candidate.
   assign cand   = req_i & ~grant_o;
   assign others = |cand;
   assign pick   = rr_pick(cand, last_q);

   // Stall every requesting master that does not currently own the bus.
   assign hold_o = req_i & ~grant_o;

   // Next-state and next-output decision for the arbitration FSM.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      grant_id_d  = grant_id_o;
      grant_vld_d = grant_vld_o;
      switch_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|req_i) begin
               state_d     = BUSY;
               grant_id_d  = pick;
               grant_vld_d = 1'b1;
               last_d      = pick;
               cnt_d       = '0;
               switch_d    = 1'b1;
            end
         end
         BUSY: begin
            if (!req_i[grant_id_o]) begin
               if (others) begin
                  // Owner released with others waiting: hand over without a bubble.
                  grant_id_d = pick;
                  last_d     = pick;
                  cnt_d      = '0;
                  switch_d   = 1'b1;
               end else begin
                  state_d     = IDLE;
                  grant_id_d  = '0;
                  grant_vld_d = 1'b0;
                  cnt_d       = '0;
               end
            end else if (!lock_i[grant_id_o] && others && (cnt_q == CNT_MAX)) begin
               // Tenure expired under contention: preempt the unlocked owner.
               grant_id_d = pick;
               last_d     = pick;
               cnt_d      = '0;
               switch_d   = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      grant_d = grant_vld_d ? (NUM_M'(1) << grant_id_d) : '0;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= 2'd3;
         grant_o     <= '0;
         grant_id_o  <= '0;
         grant_vld_o <= 1'b0;
         switch_o    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         grant_o     <= grant_d;
         grant_id_o  <= grant_id_d;
         grant_vld_o <= grant_vld_d;
         switch_o    <= switch_d;
      end
   end

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: scoreboard bench for rib_arbiter. Two instances
// (MAX_HOLD = 8 and 2) share one stimulus stream; a behavioural model
// queues expected outputs at each drive and a monitor compares after the edge.
module tb_rib_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] lock = '0;

   logic [3:0] grant_a, hold_a, grant_b, hold_b;
   logic [1:0] id_a, id_b;
   logic       vld_a, sw_a, vld_b, sw_b;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic [1:0][3:0] grant;
      logic [1:0][1:0] id;
      logic [1:0]      vld;
      logic [1:0]      sw;
   } exp_t;

   exp_t sb[$];

   // Model state per instance: index 0 -> MAX_HOLD 8, index 1 -> MAX_HOLD 2.
   int max_hold [2] = '{8, 2};
   bit m_busy   [2];
   int m_g      [2];
   int m_last   [2];
   int m_ten    [2];   // cycles the current owner has held the bus so far
   bit m_sw     [2];

   always #5 clk = ~clk;

   rib_arbiter #(.NUM_M(4), .MAX_HOLD(8)) dut_a (
      .clk(clk), .rst(rst), .req_i(req), .lock_i(lock),
      .grant_o(grant_a), .grant_id_o(id_a), .grant_vld_o(vld_a),
      .hold_o(hold_a), .switch_o(sw_a)
   );

   rib_arbiter #(.NUM_M(4), .MAX_HOLD(2)) dut_b (
      .clk(clk), .rst(rst), .req_i(req), .lock_i(lock),
      .grant_o(grant_b), .grant_id_o(id_b), .grant_vld_o(vld_b),
      .hold_o(hold_b), .switch_o(sw_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   function automatic int tb_pick(input logic [3:0] mask, input int last);
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (last + k) % 4;
         if (mask[idx]) return idx;
      end
      return last;
   endfunction

   task automatic grant_new(input int d, input int g);
      m_busy[d] = 1'b1;
      m_g[d]    = g;
      m_last[d] = g;
      m_ten[d]  = 1;
      m_sw[d]   = 1'b1;
   endtask

   task automatic model_step(input int d, input logic r, input logic [3:0] rq, input logic [3:0] lk);
      logic [3:0] oth;
      m_sw[d] = 1'b0;
      if (r) begin
         m_busy[d] = 1'b0;
         m_g[d]    = 0;
         m_last[d] = 3;
         m_ten[d]  = 0;
      end else if (!m_busy[d]) begin
         if (rq != 4'b0) grant_new(d, tb_pick(rq, m_last[d]));
      end else begin
         oth = rq;
         oth[m_g[d]] = 1'b0;
         if (!rq[m_g[d]]) begin
            if (oth != 4'b0) grant_new(d, tb_pick(oth, m_last[d]));
            else begin
               m_busy[d] = 1'b0;
               m_g[d]    = 0;
               m_ten[d]  = 0;
            end
         end else if (!lk[m_g[d]] && oth != 4'b0 && m_ten[d] >= max_hold[d]) begin
            grant_new(d, tb_pick(oth, m_last[d]));
         end else begin
            m_ten[d]++;
         end
      end
   endtask

   // Apply one cycle of stimulus away from the active edge and queue the expectation.
   task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst  = r;
         req  = rq;
         lock = lk;
         for (int d = 0; d < 2; d++) begin
            model_step(d, r, rq, lk);
            e.grant[d] = m_busy[d] ? (4'b0001 << m_g[d]) : 4'b0000;
            e.id[d]    = m_busy[d] ? 2'(m_g[d]) : 2'd0;
            e.vld[d]   = m_busy[d];
            e.sw[d]    = m_sw[d];
         end
         sb.push_back(e);
      end
   endtask

   // Monitor: compare registered outputs 1 ns after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("grant_a",  32'(grant_a), 32'(e.grant[0]));
         check("id_a",     32'(id_a),    32'(e.id[0]));
         check("vld_a",    32'(vld_a),   32'(e.vld[0]));
         check("switch_a", 32'(sw_a),    32'(e.sw[0]));
         check("hold_a",   32'(hold_a),  32'(req & ~e.grant[0]));
         check("grant_b",  32'(grant_b), 32'(e.grant[1]));
         check("id_b",     32'(id_b),    32'(e.id[1]));
         check("vld_b",    32'(vld_b),   32'(e.vld[1]));
         check("switch_b", 32'(sw_b),    32'(e.sw[1]));
         check("hold_b",   32'(hold_b),  32'(req & ~e.grant[1]));
      end
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 1'b0; m_g[d] = 0; m_last[d] = 3; m_ten[d] = 0; m_sw[d] = 1'b0;
      end

      // Reset state.
      drive(1'b1, 4'b0000, 4'b0000, 2);
      // First grant from reset, then hand-over with no idle bubble.
      drive(1'b0, 4'b0101, 4'b0000, 3);
      drive(1'b0, 4'b0100, 4'b0000, 2);
      // Tenure limit under contention, unlocked.
      drive(1'b0, 4'b1010, 4'b0000, 20);
      // Locked master 1 keeps the grant past the limit, then loses it on unlock.
      drive(1'b0, 4'b0000, 4'b0000, 1);
      drive(1'b0, 4'b0010, 4'b0010, 1);
      drive(1'b0, 4'b1010, 4'b0010, 20);
      drive(1'b0, 4'b1010, 4'b0000, 2);
      // Full contention rotation.
      drive(1'b0, 4'b1111, 4'b0000, 12);
      // Reset mid-tenure of master 2, then pointer restarts at master 0.
      drive(1'b0, 4'b0000, 4'b0000, 1);
      drive(1'b0, 4'b0100, 4'b0000, 3);
      drive(1'b1, 4'b0100, 4'b0100, 1);
      drive(1'b0, 4'b0110, 4'b0000, 3);
      // Re-grant of the same master after passing through IDLE.
      drive(1'b0, 4'b0000, 4'b0000, 1);
      drive(1'b0, 4'b0010, 4'b0000, 2);
      // Random traffic with occasional locks and resets.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] rq, lk;
         logic       r;
         rq = 4'($urandom_range(0, 15));
         lk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         r  = ($urandom_range(0, 49) == 0);
         drive(r, rq, lk, 1);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
